// File: rtl/slc3_datapath_seq_if.sv
// Control/memory interface of the SLC-3 registered datapath.
// Purpose: bundles every control strobe from the ISDU, the memory read
// data, and the architectural outputs of the datapath into one port.
// Modports:
//   master : control/memory side. Drives load enables, gates, mux selects
//            and Data_to_CPU. Observes PC, IR, MAR, MDR, Bus, CC, BEN and
//            Bus_Conflict.
//   slave  : datapath side, with the opposite directions.
// There is no valid/ready handshake here. Every strobe is sampled on each
// rising clock edge, and the outputs are plain register or bus values.
interface slc3_datapath_seq_if #(
  parameter int WIDTH = 16
);
  logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic             GatePC, GateMDR, GateALU, GateMARMUX;
  logic             DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0]       PCMUX, ADDR2MUX, ALUK;
  logic [WIDTH-1:0] Data_to_CPU;
  logic [WIDTH-1:0] PC, IR, MAR, MDR, Bus;
  logic [2:0]       CC;
  logic             BEN;
  logic             Bus_Conflict;

  modport master (
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
    output PCMUX, ADDR2MUX, ALUK, Data_to_CPU,
    input  PC, IR, MAR, MDR, Bus, CC, BEN, Bus_Conflict
  );

  modport slave (
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
    input  PCMUX, ADDR2MUX, ALUK, Data_to_CPU,
    output PC, IR, MAR, MDR, Bus, CC, BEN, Bus_Conflict
  );
endinterface

// File: rtl/slc3_datapath_seq.sv
// SLC-3 registered datapath: PC, IR, MAR, MDR, R0-R7, NZP and BEN.
// It also holds the shared bus mux, the address adder, the ALU and a sticky
// bus-conflict detector.
// Ports:
//   Clk     : system clock. All state updates on the rising edge.
//   Reset_n : synchronous, active-low reset. It overrides every load.
//   dp      : slc3_datapath_seq_if.slave. Carries the control strobes,
//             Data_to_CPU and the architectural outputs.
// The instruction fields always come from IR[15:0], whatever WIDTH is.
module slc3_datapath_seq #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [2:0]       CC_RESET = 3'b010
) (
  input logic                Clk,
  input logic                Reset_n,
  slc3_datapath_seq_if.slave dp
);

  logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q;
  logic [WIDTH-1:0] regs_q [8];
  logic [2:0]       cc_q;
  logic             ben_q;
  logic             conflict_q;

  logic [2:0]       sr1_idx, sr2_idx, dr_idx;
  logic [WIDTH-1:0] sr1_data, sr2_data;
  logic [WIDTH-1:0] addr1, addr2, addr_sum;
  logic [WIDTH-1:0] alu_b, alu_out;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] pc_next;
  logic [2:0]       gate_cnt;
  logic             multi_gate;
  logic [2:0]       cc_from_bus;
  logic             ben_next;

  // Register file indices
  assign sr1_idx  = dp.SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign sr2_idx  = ir_q[2:0];
  assign dr_idx   = dp.DRMUX ? 3'd7 : ir_q[11:9];
  assign sr1_data = regs_q[sr1_idx];
  assign sr2_data = regs_q[sr2_idx];

  // Address adder. Each offset field is sign-extended from its own MSB.
  assign addr1 = dp.ADDR1MUX ? sr1_data : pc_q;

  always_comb begin
    addr2 = '0;
    case (dp.ADDR2MUX)
      2'b00: addr2 = '0;
      2'b01: addr2 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
      2'b10: addr2 = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
      2'b11: addr2 = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
      default: addr2 = '0;
    endcase
  end

  assign addr_sum = addr1 + addr2;

  // ALU
  assign alu_b = dp.SR2MUX ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : sr2_data;

  always_comb begin
    alu_out = '0;
    case (dp.ALUK)
      2'b00: alu_out = sr1_data + alu_b;
      2'b01: alu_out = sr1_data & alu_b;
      2'b10: alu_out = ~sr1_data;
      2'b11: alu_out = sr1_data;
      default: alu_out = '0;
    endcase
  end

  // Bus mux. Anything other than exactly one gate drives 0.
  assign gate_cnt = {2'b00, dp.GatePC} + {2'b00, dp.GateMDR}
                  + {2'b00, dp.GateALU} + {2'b00, dp.GateMARMUX};
  assign multi_gate = (gate_cnt > 3'd1);

  always_comb begin
    bus = '0;
    case ({dp.GatePC, dp.GateMDR, dp.GateALU, dp.GateMARMUX})
      4'b1000: bus = pc_q;
      4'b0100: bus = mdr_q;
      4'b0010: bus = alu_out;
      4'b0001: bus = addr_sum;
      default: bus = '0;
    endcase
  end

  // PC source. PCMUX=11 holds the PC even when LD_PC is set.
  always_comb begin
    pc_next = pc_q;
    case (dp.PCMUX)
      2'b00: pc_next = pc_q + WIDTH'(1);
      2'b01: pc_next = addr_sum;
      2'b10: pc_next = bus;
      2'b11: pc_next = pc_q;
      default: pc_next = pc_q;
    endcase
  end

  // Condition codes are one-hot in N, Z, P order.
  always_comb begin
    cc_from_bus = 3'b001;
    if (bus[WIDTH-1])   cc_from_bus = 3'b100;
    else if (bus == '0) cc_from_bus = 3'b010;
  end

  // BEN uses the pre-edge IR and CC, so a same-cycle LD_IR/LD_CC does not
  // affect it.
  assign ben_next = (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mar_q      <= '0;
      mdr_q      <= '0;
      cc_q       <= CC_RESET;
      ben_q      <= 1'b0;
      conflict_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      if (dp.LD_PC)  pc_q  <= pc_next;
      if (dp.LD_MAR) mar_q <= bus;
      if (dp.LD_IR)  ir_q  <= bus;
      if (dp.LD_MDR) mdr_q <= dp.MIO_EN ? dp.Data_to_CPU : bus;
      if (dp.LD_REG) regs_q[dr_idx] <= bus;
      if (dp.LD_CC)  cc_q  <= cc_from_bus;
      if (dp.LD_BEN) ben_q <= ben_next;
      // Once set, the conflict flag stays set until reset.
      if (multi_gate) conflict_q <= 1'b1;
    end
  end

  assign dp.PC           = pc_q;
  assign dp.IR           = ir_q;
  assign dp.MAR          = mar_q;
  assign dp.MDR          = mdr_q;
  assign dp.Bus          = bus;
  assign dp.CC           = cc_q;
  assign dp.BEN          = ben_q;
  assign dp.Bus_Conflict = conflict_q;

endmodule

// File: tb/tb_slc3_datapath_seq.sv
module tb_slc3_datapath_seq;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  slc3_datapath_seq_if #(.WIDTH(W)) dp ();

  slc3_datapath_seq #(
    .WIDTH(W), .RESET_PC(16'h3000), .CC_RESET(3'b010)
  ) dut (
    .Clk(clk), .Reset_n(reset_n), .dp(dp)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: architectural state kept as plain values
  logic [W-1:0] m_pc, m_ir, m_mar, m_mdr;
  logic [W-1:0] m_r [8];
  logic [2:0]   m_cc;
  logic         m_ben, m_conf;
  bit           model_valid = 0;

  function automatic logic [W-1:0] sext(input int v, input int bits);
    int s;
    s = v & ((1 << bits) - 1);
    if (s >= (1 << (bits - 1))) s = s - (1 << bits);
    return W'(s);
  endfunction

  function automatic int field(input logic [W-1:0] v, input int hi, input int lo);
    return (int'(v) >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic int gates_on();
    return int'(dp.GatePC) + int'(dp.GateMDR) + int'(dp.GateALU) + int'(dp.GateMARMUX);
  endfunction

  function automatic logic [W-1:0] model_addr();
    int sr1;
    logic [W-1:0] base, off;
    sr1 = dp.SR1MUX ? field(m_ir, 8, 6) : field(m_ir, 11, 9);
    base = dp.ADDR1MUX ? m_r[sr1] : m_pc;
    case (dp.ADDR2MUX)
      2'd0: off = '0;
      2'd1: off = sext(int'(m_ir), 11);
      2'd2: off = sext(int'(m_ir), 9);
      default: off = sext(int'(m_ir), 6);
    endcase
    return W'((int'(base) + int'(off)) % 65536);
  endfunction

  function automatic logic [W-1:0] model_alu();
    int sr1;
    logic [W-1:0] a, b;
    sr1 = dp.SR1MUX ? field(m_ir, 8, 6) : field(m_ir, 11, 9);
    a = m_r[sr1];
    b = dp.SR2MUX ? sext(int'(m_ir), 5) : m_r[field(m_ir, 2, 0)];
    case (dp.ALUK)
      2'd0: return W'((int'(a) + int'(b)) % 65536);
      2'd1: return a & b;
      2'd2: return W'(65535 - int'(a));
      default: return a;
    endcase
  endfunction

  function automatic logic [W-1:0] model_bus();
    if (gates_on() != 1) return '0;
    if (dp.GatePC)  return m_pc;
    if (dp.GateMDR) return m_mdr;
    if (dp.GateALU) return model_alu();
    return model_addr();
  endfunction

  // driver tasks
  task automatic idle();
    reset_n = 1'b1;
    {dp.LD_MAR, dp.LD_MDR, dp.LD_IR, dp.LD_BEN, dp.LD_CC, dp.LD_REG, dp.LD_PC} = '0;
    {dp.GatePC, dp.GateMDR, dp.GateALU, dp.GateMARMUX} = '0;
    {dp.DRMUX, dp.SR1MUX, dp.SR2MUX, dp.ADDR1MUX, dp.MIO_EN} = '0;
    dp.PCMUX = 2'b00; dp.ADDR2MUX = 2'b00; dp.ALUK = 2'b00;
    dp.Data_to_CPU = '0;
  endtask

  // Inputs are set by the caller after a negedge. The bus is checked before
  // the edge, and the registered outputs are checked #1 after it.
  task automatic step();
    logic [W-1:0] b, npc;
    int dr;
    logic [2:0] ncc;
    #1;
    b = model_bus();
    if (model_valid) check_val("bus", dp.Bus, b);
    if (!reset_n) begin
      m_pc = 16'h3000; m_ir = '0; m_mar = '0; m_mdr = '0;
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_cc = 3'b010; m_ben = 1'b0; m_conf = 1'b0;
      model_valid = 1;
    end else begin
      npc = m_pc;
      if (dp.LD_PC) begin
        case (dp.PCMUX)
          2'd0: npc = W'((int'(m_pc) + 1) % 65536);
          2'd1: npc = model_addr();
          2'd2: npc = b;
          default: npc = m_pc;
        endcase
      end
      if (b == 0) ncc = 3'b010;
      else if (int'(b) >= 32768) ncc = 3'b100;
      else ncc = 3'b001;
      dr = dp.DRMUX ? 7 : field(m_ir, 11, 9);
      if (dp.LD_BEN) m_ben = |(3'(field(m_ir, 11, 9)) & m_cc);
      if (dp.LD_MAR) m_mar = b;
      if (dp.LD_MDR) m_mdr = dp.MIO_EN ? dp.Data_to_CPU : b;
      if (dp.LD_REG) m_r[dr] = b;
      if (dp.LD_CC)  m_cc = ncc;
      if (dp.LD_IR)  m_ir = b;
      m_pc = npc;
      if (gates_on() > 1) m_conf = 1'b1;
    end
    exp_q.push_back(m_pc);  exp_q.push_back(m_ir);
    exp_q.push_back(m_mar); exp_q.push_back(m_mdr);
    exp_q.push_back({13'd0, m_cc}); exp_q.push_back({15'd0, m_ben});
    exp_q.push_back({15'd0, m_conf});
    @(posedge clk);
    #1;
    check_val("pc",  dp.PC,  exp_q.pop_front());
    check_val("ir",  dp.IR,  exp_q.pop_front());
    check_val("mar", dp.MAR, exp_q.pop_front());
    check_val("mdr", dp.MDR, exp_q.pop_front());
    check_val("cc",  {13'd0, dp.CC},  exp_q.pop_front());
    check_val("ben", {15'd0, dp.BEN}, exp_q.pop_front());
    check_val("conflict", {15'd0, dp.Bus_Conflict}, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic mem_to_mdr(input logic [W-1:0] v);
    idle(); dp.MIO_EN = 1; dp.Data_to_CPU = v; dp.LD_MDR = 1; step();
  endtask

  task automatic load_ir(input logic [W-1:0] v);
    mem_to_mdr(v);
    idle(); dp.GateMDR = 1; dp.LD_IR = 1; step();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    @(negedge clk);

    // Reset with every load enable high
    idle(); reset_n = 0;
    {dp.LD_MAR, dp.LD_MDR, dp.LD_IR, dp.LD_BEN, dp.LD_CC, dp.LD_REG, dp.LD_PC} = '1;
    dp.GatePC = 1;
    step();
    check_val("rst_pc", dp.PC, 16'h3000);
    check_val("rst_cc", {13'd0, dp.CC}, 16'h0002);
    check_val("rst_ben", {15'd0, dp.BEN}, 16'h0000);
    check_val("rst_ir", dp.IR, 16'h0000);
    check_val("rst_mdr", dp.MDR, 16'h0000);
    idle(); dp.GateALU = 1; dp.ALUK = 2'b11; #1;
    check_val("rst_r0", dp.Bus, 16'h0000);

    // PC+1 wraps from all-ones
    mem_to_mdr(16'hFFFF);
    idle(); dp.GateMDR = 1; dp.LD_PC = 1; dp.PCMUX = 2'b10; step();
    idle(); dp.GatePC = 1; dp.LD_MAR = 1; dp.LD_PC = 1; dp.PCMUX = 2'b00; step();
    check_val("wrap_mar", dp.MAR, 16'hFFFF);
    check_val("wrap_pc", dp.PC, 16'h0000);

    // ADD R1,R1,#1 with R1=7FFF
    load_ir(16'h1261);
    mem_to_mdr(16'h7FFF);
    idle(); dp.GateMDR = 1; dp.LD_REG = 1; step();
    idle(); dp.SR1MUX = 1; dp.SR2MUX = 1; dp.ALUK = 2'b00; dp.GateALU = 1;
    dp.LD_REG = 1; dp.LD_CC = 1; step();
    check_val("add_cc", {13'd0, dp.CC}, 16'h0004);
    idle(); dp.SR1MUX = 1; dp.ALUK = 2'b11; dp.GateALU = 1; #1;
    check_val("add_r1", dp.Bus, 16'h8000);
    step();

    // BEN evaluation
    load_ir(16'h0A05);
    idle(); dp.LD_BEN = 1; step();
    check_val("ben_n", {15'd0, dp.BEN}, 16'h0001);
    idle(); dp.LD_CC = 1; step();
    idle(); dp.LD_BEN = 1; step();
    check_val("ben_z", {15'd0, dp.BEN}, 16'h0000);

    // Bus conflict is sticky until reset
    idle(); dp.GatePC = 1; dp.GateMDR = 1; #1;
    check_val("conf_bus", dp.Bus, 16'h0000);
    step();
    idle(); step(); step();
    check_val("conf_sticky", {15'd0, dp.Bus_Conflict}, 16'h0001);
    idle(); reset_n = 0; step();
    check_val("conf_clr", {15'd0, dp.Bus_Conflict}, 16'h0000);

    // Memory read into MDR, then into IR
    mem_to_mdr(16'hBEEF);
    idle(); dp.GateMDR = 1; dp.LD_IR = 1; step();
    check_val("mio_ir", dp.IR, 16'hBEEF);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int g;
      idle();
      reset_n = ($urandom_range(0, 39) != 0);
      {dp.LD_MAR, dp.LD_MDR, dp.LD_IR, dp.LD_BEN, dp.LD_CC, dp.LD_REG, dp.LD_PC} = 7'($urandom);
      {dp.DRMUX, dp.SR1MUX, dp.SR2MUX, dp.ADDR1MUX, dp.MIO_EN} = 5'($urandom);
      dp.PCMUX = 2'($urandom); dp.ADDR2MUX = 2'($urandom); dp.ALUK = 2'($urandom);
      dp.Data_to_CPU = 16'($urandom);
      g = $urandom_range(0, 15);
      if (g == 15) begin
        {dp.GatePC, dp.GateMDR, dp.GateALU, dp.GateMARMUX} = 4'b0110;
      end else if (g >= 3) begin
        case ($urandom_range(0, 3))
          0: dp.GatePC = 1;
          1: dp.GateMDR = 1;
          2: dp.GateALU = 1;
          default: dp.GateMARMUX = 1;
        endcase
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
